// File: rtl/jpeg_pkg.sv
// Shared constants and helpers for the JPEG front end.
// Holds the fixed-point format of the colour converter output, the sample
// format fed to the DCT, and the 8x8 block geometry.
package jpeg_pkg;

  localparam int SCALE              = 16;   // fractional bits of incoming components
  localparam int FIXED_POINT_LENGTH = 32;   // incoming component width
  localparam int SAMPLE_WIDTH       = 8;    // signed, level-shifted sample width
  localparam int BLOCK_DIM          = 8;    // block edge
  localparam int BLOCK_SIZE         = 64;   // pixels per block
  localparam int LEVEL_SHIFT        = 128;
  localparam int SAMPLE_MIN         = 0;
  localparam int SAMPLE_MAX         = 255;

  localparam int PIX_IDX_W = 6;             // index of a pixel within a block
  localparam int ROW_IDX_W = 3;             // index of a row within a block
  localparam int COL_IDX_W = 3;             // index of a column within a row
  localparam int ROW_BITS  = BLOCK_DIM * SAMPLE_WIDTH;

  typedef logic [SAMPLE_WIDTH-1:0] sample_t;
  typedef logic [PIX_IDX_W-1:0]    pix_idx_t;
  typedef logic [ROW_IDX_W-1:0]    row_idx_t;

  localparam pix_idx_t LAST_PIXEL = 6'd63;
  localparam row_idx_t LAST_ROW   = 3'd7;

  // Unsigned 0..255 value to signed two's-complement sample (value - 128).
  function automatic sample_t level_shift(input sample_t value);
    return value - sample_t'(LEVEL_SHIFT);
  endfunction

endpackage

// File: rtl/fixed_to_sample.sv
// Converts one fixed-point colour component to a signed 8-bit DCT sample:
// round half up to an integer, clamp to 0..255, subtract 128.
// Ports:
//   x      - component, two's complement with SCALE fractional bits
//   sample - signed level-shifted sample
module fixed_to_sample
  import jpeg_pkg::*;
(
  input  logic [FIXED_POINT_LENGTH-1:0] x,
  output logic [SAMPLE_WIDTH-1:0]       sample
);

  localparam int SUM_W = FIXED_POINT_LENGTH + 1;   // one guard bit so +0.5 cannot overflow
  localparam int V_W   = SUM_W - SCALE;            // integer part, still signed
  localparam logic [SUM_W-1:0] ROUND_BIAS = SUM_W'(1) << (SCALE - 1);

  logic [SUM_W-1:0]        sum;
  logic [V_W-1:0]          v;
  logic [SAMPLE_WIDTH-1:0] clamped;
  logic                    unused_frac;

  // Round, saturate and level-shift one component.
  always_comb begin
    sum         = {x[FIXED_POINT_LENGTH-1], x} + ROUND_BIAS;
    // Taking the upper bits of the sign-extended sum is the arithmetic shift.
    v           = sum[SUM_W-1:SCALE];
    unused_frac = ^sum[SCALE-1:0];
    if (v[V_W-1]) begin
      clamped = SAMPLE_WIDTH'(SAMPLE_MIN);
    end else if (|v[V_W-2:SAMPLE_WIDTH]) begin
      clamped = SAMPLE_WIDTH'(SAMPLE_MAX);
    end else begin
      clamped = v[SAMPLE_WIDTH-1:0];
    end
    sample = level_shift(clamped);
  end

endmodule

// File: rtl/ycbcr_block_packer.sv
// Collects converted Y/Cb/Cr pixels into a ping-pong pair of 8x8 block
// buffers and streams each finished block out one row per beat.
// Ports:
//   clk, rst                - clock, asynchronous active-high reset
//   in_valid / in_ready     - pixel handshake (raster order within block)
//   y_in, cb_in, cr_in      - fixed-point components from the converter
//   out_valid / out_ready   - row handshake towards the DCT
//   out_row, out_last       - row index within the block, high on row 7
//   y_row, cb_row, cr_row   - eight samples, column j at bits [8j+7:8j]
module ycbcr_block_packer
  import jpeg_pkg::*;
(
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          in_valid,
  output logic                          in_ready,
  input  logic [FIXED_POINT_LENGTH-1:0] y_in,
  input  logic [FIXED_POINT_LENGTH-1:0] cb_in,
  input  logic [FIXED_POINT_LENGTH-1:0] cr_in,
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic [ROW_IDX_W-1:0]          out_row,
  output logic                          out_last,
  output logic [ROW_BITS-1:0]           y_row,
  output logic [ROW_BITS-1:0]           cb_row,
  output logic [ROW_BITS-1:0]           cr_row
);

  // Block storage, indexed [bank][pixel]; contents are never reset.
  sample_t y_mem  [0:1][0:BLOCK_SIZE-1];
  sample_t cb_mem [0:1][0:BLOCK_SIZE-1];
  sample_t cr_mem [0:1][0:BLOCK_SIZE-1];

  logic [1:0] full;
  logic       wr_bank;
  logic       rd_bank;
  pix_idx_t   wr_cnt;

  logic [1:0] full_nxt;
  logic       wr_bank_nxt;
  logic       rd_bank_nxt;
  pix_idx_t   wr_cnt_nxt;
  row_idx_t   out_row_nxt;

  logic    wr_fire;
  logic    rd_fire;
  sample_t y_smp;
  sample_t cb_smp;
  sample_t cr_smp;

  fixed_to_sample u_y  (.x(y_in),  .sample(y_smp));
  fixed_to_sample u_cb (.x(cb_in), .sample(cb_smp));
  fixed_to_sample u_cr (.x(cr_in), .sample(cr_smp));

  // Handshake qualifiers come straight from registered bank state.
  assign in_ready  = ~full[wr_bank];
  assign out_valid = full[rd_bank];
  assign out_last  = (out_row == LAST_ROW);
  assign wr_fire   = in_valid & in_ready;
  assign rd_fire   = out_valid & out_ready;

  // Next-state for bank flags and counters. A fill and a drain finishing in
  // the same cycle always target different banks (the write bank is empty,
  // the read bank is full), so both flag updates apply independently.
  always_comb begin
    full_nxt    = full;
    wr_bank_nxt = wr_bank;
    rd_bank_nxt = rd_bank;
    wr_cnt_nxt  = wr_cnt;
    out_row_nxt = out_row;

    if (wr_fire) begin
      if (wr_cnt == LAST_PIXEL) begin
        full_nxt[wr_bank] = 1'b1;
        wr_bank_nxt       = ~wr_bank;
        wr_cnt_nxt        = 6'd0;
      end else begin
        wr_cnt_nxt = wr_cnt + 6'd1;
      end
    end else begin
      wr_cnt_nxt = wr_cnt;
    end

    if (rd_fire) begin
      if (out_row == LAST_ROW) begin
        full_nxt[rd_bank] = 1'b0;
        rd_bank_nxt       = ~rd_bank;
        out_row_nxt       = 3'd0;
      end else begin
        out_row_nxt = out_row + 3'd1;
      end
    end else begin
      out_row_nxt = out_row;
    end
  end

  // Bank flags and counters; reset discards any partial or undrained block.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      full    <= 2'b00;
      wr_bank <= 1'b0;
      rd_bank <= 1'b0;
      wr_cnt  <= 6'd0;
      out_row <= 3'd0;
    end else begin
      full    <= full_nxt;
      wr_bank <= wr_bank_nxt;
      rd_bank <= rd_bank_nxt;
      wr_cnt  <= wr_cnt_nxt;
      out_row <= out_row_nxt;
    end
  end

  // Pixel write into the current fill bank (raster position = wr_cnt).
  always_ff @(posedge clk) begin
    if (wr_fire) begin
      y_mem[wr_bank][wr_cnt]  <= y_smp;
      cb_mem[wr_bank][wr_cnt] <= cb_smp;
      cr_mem[wr_bank][wr_cnt] <= cr_smp;
    end
  end

  // Combinational row read from the drain bank; held while out_row holds.
  always_comb begin
    y_row  = '0;
    cb_row = '0;
    cr_row = '0;
    for (int j = 0; j < BLOCK_DIM; j++) begin
      y_row[j*SAMPLE_WIDTH +: SAMPLE_WIDTH]  = y_mem[rd_bank][{out_row, j[COL_IDX_W-1:0]}];
      cb_row[j*SAMPLE_WIDTH +: SAMPLE_WIDTH] = cb_mem[rd_bank][{out_row, j[COL_IDX_W-1:0]}];
      cr_row[j*SAMPLE_WIDTH +: SAMPLE_WIDTH] = cr_mem[rd_bank][{out_row, j[COL_IDX_W-1:0]}];
    end
  end

endmodule

// File: tb/tb_ycbcr_block_packer.sv
// Self-checking bench for ycbcr_block_packer. The reference keeps a queue of
// completed blocks (flat list of pixels) plus the block being filled, and
// derives readiness from how many whole blocks are waiting.
module tb_ycbcr_block_packer;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] y_in, cb_in, cr_in;
  logic        out_valid;
  logic        out_ready;
  logic [2:0]  out_row;
  logic        out_last;
  logic [63:0] y_row, cb_row, cr_row;

  always #5 clk = ~clk;

  ycbcr_block_packer dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready),
    .y_in(y_in), .cb_in(cb_in), .cr_in(cr_in),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_row(out_row), .out_last(out_last),
    .y_row(y_row), .cb_row(cb_row), .cr_row(cr_row)
  );

  int compared   = 0;
  int mismatched = 0;

  bit [23:0] blkq[$];   // completed, undrained blocks; {y,cb,cr} per pixel
  bit [23:0] cur[$];    // block being filled
  int        rd_row = 0;
  bit        took;
  logic [31:0] p_y, p_cb, p_cr;

  logic [31:0] corner_in  [5] = '{32'h0080_0000, 32'h00FF_8000, 32'hFFFF_0000, 32'h0000_7FFF, 32'h0000_8000};
  logic [7:0]  corner_exp [5] = '{8'h00, 8'h7F, 8'h80, 8'h80, 8'h81};

  // Round half up, clamp to 0..255, subtract 128.
  function automatic bit [7:0] ref_sample(input logic [31:0] x);
    longint v;
    v = longint'($signed(x));
    v = (v + 64'sd32768) >>> 16;
    if (v < 0) v = 0;
    if (v > 255) v = 255;
    return 8'(v - 128);
  endfunction

  function automatic logic [31:0] rnd_comp();
    if ($urandom_range(0, 9) == 0) return $urandom;
    return 32'($urandom_range(0, 290 * 65536)) - 32'(20 * 65536);
  endfunction

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic check_outputs();
    int nfull;
    logic [63:0] ey, ecb, ecr;
    nfull = blkq.size() / 64;
    check("in_ready", 64'(in_ready), 64'(nfull < 2));
    check("out_valid", 64'(out_valid), 64'(nfull > 0));
    check("out_row", 64'(out_row), 64'(rd_row));
    if (nfull > 0) begin
      for (int j = 0; j < 8; j++) begin
        ey[8*j +: 8]  = blkq[rd_row*8 + j][23:16];
        ecb[8*j +: 8] = blkq[rd_row*8 + j][15:8];
        ecr[8*j +: 8] = blkq[rd_row*8 + j][7:0];
      end
      check("out_last", 64'(out_last), 64'(rd_row == 7));
      check("y_row", y_row, ey);
      check("cb_row", cb_row, ecb);
      check("cr_row", cr_row, ecr);
    end
  endtask

  // One clock: drive at negedge, check, then advance the model at posedge.
  task automatic step(input bit iv, input bit ordy);
    int nfull;
    bit [23:0] d;
    @(negedge clk);
    in_valid  = iv;
    out_ready = ordy;
    y_in = p_y; cb_in = p_cb; cr_in = p_cr;
    #1 check_outputs();
    nfull = blkq.size() / 64;
    @(posedge clk);
    took = iv && (nfull < 2);
    if (ordy && nfull > 0) begin
      rd_row++;
      if (rd_row == 8) begin
        rd_row = 0;
        repeat (64) d = blkq.pop_front();
      end
    end
    if (took) begin
      cur.push_back({ref_sample(p_y), ref_sample(p_cb), ref_sample(p_cr)});
      if (cur.size() == 64) begin
        foreach (cur[i]) blkq.push_back(cur[i]);
        cur.delete();
      end
    end
  endtask

  task automatic send(input logic [31:0] y, input logic [31:0] cb, input logic [31:0] cr, input bit ordy);
    p_y = y; p_cb = cb; p_cr = cr;
    took = 1'b0;
    for (int n = 0; n < 300 && !took; n++) step(1'b1, ordy);
    check("send_accepted", 64'(took), 64'd1);
  endtask

  task automatic send_rand(input int count, input bit ordy);
    for (int n = 0; n < count; n++) send(rnd_comp(), rnd_comp(), rnd_comp(), ordy);
  endtask

  task automatic drain_all();
    for (int n = 0; n < 400 && (blkq.size() > 0); n++) step(1'b0, 1'b1);
    check("drain_done", 64'(blkq.size()), 64'd0);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
    #1;
    check("rst_in_ready", 64'(in_ready), 64'd1);
    check("rst_out_valid", 64'(out_valid), 64'd0);
    check("rst_out_row", 64'(out_row), 64'd0);
    check("rst_out_last", 64'(out_last), 64'd0);
    blkq.delete(); cur.delete(); rd_row = 0;
    #2 rst = 1'b0;
  endtask

  initial begin
    int accepted;
    logic [63:0] exp_row;
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
    y_in = '0; cb_in = '0; cr_in = '0;
    p_y = '0; p_cb = '0; p_cr = '0;
    do_reset();

    // Arithmetic corners as pixel 0 of successive blocks.
    for (int i = 0; i < 5; i++) begin
      send(corner_in[i], rnd_comp(), rnd_comp(), 1'b0);
      send_rand(63, 1'b0);
      step(1'b0, 1'b0);
      #1 check("corner_y", 64'(y_row[7:0]), 64'(corner_exp[i]));
      drain_all();
    end

    // Single block with known ramp, drained at full rate.
    for (int k = 0; k < 64; k++) send(32'((k + 128) << 16), rnd_comp(), rnd_comp(), 1'b1);
    #1 check("ramp_valid_at_fill", 64'(out_valid), 64'd1);
    for (int r = 0; r < 8; r++) begin
      for (int j = 0; j < 8; j++) exp_row[8*j +: 8] = 8'(8*r + j);
      #1 check("ramp_row", y_row, exp_row);
      check("ramp_last", 64'(out_last), 64'(r == 7));
      step(1'b0, 1'b1);
    end
    #1 check("ramp_valid_after", 64'(out_valid), 64'd0);

    // Backpressure: two blocks fill, pixel 129 waits, then stalled drain.
    do_reset();
    send_rand(128, 1'b0);
    p_y = rnd_comp(); p_cb = rnd_comp(); p_cr = rnd_comp();
    for (int n = 0; n < 5; n++) begin
      step(1'b1, 1'b0);
      check("bp_not_taken", 64'(took), 64'd0);
    end
    send(p_y, p_cb, p_cr, 1'b1);
    send_rand(1, 1'b1);
    for (int n = 0; n < 400 && (blkq.size() > 0); n++) step(1'b0, bit'($urandom_range(0, 1)));
    check("bp_drained", 64'(blkq.size()), 64'd0);

    // Reset mid-fill discards the partial block.
    do_reset();
    send_rand(30, 1'b1);
    do_reset();
    for (int k = 0; k < 64; k++) send(32'((k + 128) << 16), rnd_comp(), rnd_comp(), 1'b1);
    #1 check("rst_block_first", 64'(y_row[7:0]), 64'h00);
    drain_all();

    // Fill-complete of bank 1 coincides with row-7 transfer of bank 0.
    do_reset();
    send_rand(64, 1'b0);
    send_rand(63, 1'b0);
    for (int n = 0; n < 7; n++) step(1'b0, 1'b1);
    p_y = rnd_comp(); p_cb = rnd_comp(); p_cr = rnd_comp();
    step(1'b1, 1'b1);
    check("sim_taken", 64'(took), 64'd1);
    #1;
    check("sim_next_valid", 64'(out_valid), 64'd1);
    check("sim_next_row", 64'(out_row), 64'd0);
    check("sim_in_ready", 64'(in_ready), 64'd1);
    p_y = rnd_comp(); p_cb = rnd_comp(); p_cr = rnd_comp();
    step(1'b1, 1'b0);
    check("sim_bank0_write", 64'(took), 64'd1);
    drain_all();

    // Random valid/ready traffic over 20 blocks.
    do_reset();
    accepted = 0;
    p_y = rnd_comp(); p_cb = rnd_comp(); p_cr = rnd_comp();
    for (int n = 0; n < 30000 && accepted < 1280; n++) begin
      step(bit'($urandom_range(0, 1)), ($urandom_range(0, 9) < 6));
      if (took) begin
        accepted++;
        p_y = rnd_comp(); p_cb = rnd_comp(); p_cr = rnd_comp();
      end
    end
    check("rand_accepted", 64'(accepted), 64'd1280);
    drain_all();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
